// File: rtl/event_pulser_pkg.sv
// -----------------------------------------------------------------------------
// event_pulser_pkg
//   Shared types and helpers for the event_pulser block.
//   - state_e : FSM state encoding (IDLE / PULSE / GAP)
//   - max_int : elaboration-time maximum, used to size the shared down-counter
// -----------------------------------------------------------------------------
package event_pulser_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_PULSE = 2'd1,
      ST_GAP   = 2'd2
   } state_e;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage : event_pulser_pkg

// File: rtl/oneshot_timer.sv
// -----------------------------------------------------------------------------
// oneshot_timer
//   Loadable saturating down-counter. A load takes priority over counting;
//   once the value reaches zero it stays there until the next load.
//   Ports:
//     clk, rst_n  : clock, asynchronous active-low reset (value clears to 0)
//     load        : load load_value on the next posedge
//     load_value  : value to load
//     count_en    : decrement on the next posedge (ignored while loading)
//     done        : registered value is zero
//     value       : current registered count
// -----------------------------------------------------------------------------
module oneshot_timer #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   input  logic             count_en,
   output logic             done,
   output logic [WIDTH-1:0] value
);

   logic [WIDTH-1:0] value_q;
   logic [WIDTH-1:0] value_d;

   // NOTE: every signal assigned in always_comb gets a default on entry so no
   // path through the block can leave it unassigned and infer a latch.
   always_comb begin
      value_d = value_q;
      if (load) begin
         value_d = load_value;
      end else if (count_en && (value_q != '0)) begin
         value_d = value_q - WIDTH'(1);
      end
   end

   // NOTE: sequential state is updated with non-blocking assignments only, so
   // every flop samples the pre-edge values of all other flops.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         value_q <= '0;
      end else begin
         value_q <= value_d;
      end
   end

   assign value = value_q;
   assign done  = (value_q == '0);

endmodule : oneshot_timer

// File: rtl/event_pulser.sv
// -----------------------------------------------------------------------------
// event_pulser
//   Turns single-cycle event strobes into clean pulses on an output line with
//   an exact active width and an exact forced idle gap after every pulse.
//   Events arriving while a pulse or gap is running are queued (bounded).
//   Ports:
//     clk       : clock, all logic on posedge
//     rst_n     : asynchronous active-low reset
//     in_edge   : event strobe, each high cycle is one event
//     out_line  : registered pulsed line (idle level = OUTPUT_WHEN_IDLE)
//     busy      : registered, high while in PULSE or GAP
//     pending   : queued events not yet started
//     dropped   : one-cycle strobe, an event was lost because the queue was full
// -----------------------------------------------------------------------------
module event_pulser
   import event_pulser_pkg::*;
#(
   parameter bit OUTPUT_WHEN_IDLE = 1'b1,
   parameter int PULSE_CYCLES     = 1000,
   parameter int GAP_CYCLES       = 1000,
   parameter int MAX_PENDING      = 15
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic                               in_edge,
   output logic                               out_line,
   output logic                               busy,
   output logic [$clog2(MAX_PENDING+1)-1:0]   pending,
   output logic                               dropped
);

   localparam int PEND_W = $clog2(MAX_PENDING + 1);
   localparam int TMR_W  = $clog2(max_int(PULSE_CYCLES, GAP_CYCLES) + 1);

   localparam logic [TMR_W-1:0]  PULSE_LOAD = TMR_W'(PULSE_CYCLES - 1);
   localparam logic [TMR_W-1:0]  GAP_LOAD   = TMR_W'(GAP_CYCLES - 1);
   localparam logic [PEND_W-1:0] PEND_MAX   = PEND_W'(MAX_PENDING);

   localparam logic LINE_IDLE   = OUTPUT_WHEN_IDLE;
   localparam logic LINE_ACTIVE = ~OUTPUT_WHEN_IDLE;

   state_e            state_q, state_d;
   logic              out_line_q, out_line_d;
   logic              busy_q, busy_d;
   logic [PEND_W-1:0] pending_q, pending_d;
   logic              dropped_q, dropped_d;

   logic              tmr_load;
   logic [TMR_W-1:0]  tmr_load_value;
   logic              tmr_count_en;
   logic              tmr_done;
   logic [TMR_W-1:0]  tmr_value;
   logic              consume;

   // Down-counter shared by the PULSE and GAP phases; reloaded on every phase
   // entry and counted down while the FSM is not idle.
   oneshot_timer #(
      .WIDTH (TMR_W)
   ) u_timer (
      .clk        (clk),
      .rst_n      (rst_n),
      .load       (tmr_load),
      .load_value (tmr_load_value),
      .count_en   (tmr_count_en),
      .done       (tmr_done),
      .value      (tmr_value)
   );

   assign tmr_count_en = (state_q != ST_IDLE);

   // State register together with the registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         out_line_q <= LINE_IDLE;
         busy_q     <= 1'b0;
         pending_q  <= '0;
         dropped_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         out_line_q <= out_line_d;
         busy_q     <= busy_d;
         pending_q  <= pending_d;
         dropped_q  <= dropped_d;
      end
   end

   // Next-state logic. "consume" marks the cycle in which a new pulse starts,
   // taking either the strobe of this cycle or one queued event.
   always_comb begin
      state_d        = state_q;
      tmr_load       = 1'b0;
      tmr_load_value = PULSE_LOAD;
      consume        = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (in_edge) begin
               state_d        = ST_PULSE;
               tmr_load       = 1'b1;
               tmr_load_value = PULSE_LOAD;
               consume        = 1'b1;
            end
         end
         ST_PULSE: begin
            if (tmr_done) begin
               state_d        = ST_GAP;
               tmr_load       = 1'b1;
               tmr_load_value = GAP_LOAD;
            end
         end
         ST_GAP: begin
            if (tmr_done) begin
               if ((pending_q != '0) || in_edge) begin
                  state_d        = ST_PULSE;
                  tmr_load       = 1'b1;
                  tmr_load_value = PULSE_LOAD;
                  consume        = 1'b1;
               end else begin
                  state_d = ST_IDLE;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Output logic: line level and busy follow the next state so they are
   // registered alongside it; the queue counter only moves while busy.
   always_comb begin
      out_line_d = (state_d == ST_PULSE) ? LINE_ACTIVE : LINE_IDLE;
      busy_d     = (state_d != ST_IDLE);
      pending_d  = pending_q;
      dropped_d  = 1'b0;
      if (state_q != ST_IDLE) begin
         if (in_edge && consume) begin
            // The new strobe takes the slot of the event being started.
            pending_d = pending_q;
         end else if (in_edge) begin
            if (pending_q < PEND_MAX) begin
               pending_d = pending_q + PEND_W'(1);
            end else begin
               dropped_d = 1'b1;
            end
         end else if (consume) begin
            pending_d = pending_q - PEND_W'(1);
         end
      end
   end

   assign out_line = out_line_q;
   assign busy     = busy_q;
   assign pending  = pending_q;
   assign dropped  = dropped_q;

   // The timer always rests at zero whenever the FSM is idle.
   idle_timer_parked: assert property (@(posedge clk) disable iff (!rst_n)
      (state_q == ST_IDLE) |-> (tmr_value == '0));

endmodule : event_pulser

// File: tb/tb_event_pulser.sv
// -----------------------------------------------------------------------------
// tb_event_pulser
//   Two instances share clock, reset and strobe: one with the line idling high,
//   one idling low. An event-schedule model predicts every output each cycle.
// -----------------------------------------------------------------------------
module tb_event_pulser;

   localparam int P   = 4;
   localparam int G   = 3;
   localparam int MAXP = 2;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       in_edge = 1'b0;

   logic       dut_out, inv_out, dut_busy, inv_busy, dut_drop, inv_drop;
   logic [1:0] dut_pend, inv_pend;

   int n_checks = 0;
   int n_fail   = 0;

   event_pulser #(
      .OUTPUT_WHEN_IDLE (1'b1),
      .PULSE_CYCLES     (P),
      .GAP_CYCLES       (G),
      .MAX_PENDING      (MAXP)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_edge  (in_edge),
      .out_line (dut_out),
      .busy     (dut_busy),
      .pending  (dut_pend),
      .dropped  (dut_drop)
   );

   event_pulser #(
      .OUTPUT_WHEN_IDLE (1'b0),
      .PULSE_CYCLES     (P),
      .GAP_CYCLES       (G),
      .MAX_PENDING      (MAXP)
   ) dut_inv (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_edge  (in_edge),
      .out_line (inv_out),
      .busy     (inv_busy),
      .pending  (inv_pend),
      .dropped  (inv_drop)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------------------------------------------------------------------
   // Model: a list of pulse start times. A pulse starting at s drives the line
   // active for [s, s+P) and keeps busy for [s, s+P+G). A new event starts at
   // max(now, last_start+P+G); it is accepted if a queued pulse starts right now
   // or fewer than MAXP pulses are still waiting.
   // ---------------------------------------------------------------------------
   int   t_m = 0;
   int   starts[$];
   int   last_start = -1000;
   int   cand;
   int   pend_now;
   bit   consumed_now;
   logic exp_active = 1'b0;
   logic exp_busy   = 1'b0;
   logic exp_drop   = 1'b0;
   int   exp_pend   = 0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         starts.delete();
         last_start = -1000;
         exp_active = 1'b0;
         exp_busy   = 1'b0;
         exp_drop   = 1'b0;
         exp_pend   = 0;
      end else begin
         t_m++;
         consumed_now = 1'b0;
         pend_now     = 0;
         foreach (starts[i]) begin
            if (starts[i] == t_m) consumed_now = 1'b1;
            if (starts[i] > t_m)  pend_now++;
         end
         exp_drop = 1'b0;
         if (in_edge) begin
            if (consumed_now || (pend_now < MAXP)) begin
               cand = (last_start + P + G > t_m) ? last_start + P + G : t_m;
               starts.push_back(cand);
               last_start = cand;
            end else begin
               exp_drop = 1'b1;
            end
         end
         while ((starts.size() > 0) && (starts[0] + P + G <= t_m)) void'(starts.pop_front());
         exp_active = 1'b0;
         exp_busy   = 1'b0;
         exp_pend   = 0;
         foreach (starts[i]) begin
            if ((starts[i] <= t_m) && (t_m < starts[i] + P))     exp_active = 1'b1;
            if ((starts[i] <= t_m) && (t_m < starts[i] + P + G)) exp_busy   = 1'b1;
            if (starts[i] > t_m) exp_pend++;
         end
      end
   end

   // Every-cycle comparison, away from the active edge.
   always @(negedge clk) begin
      check("out_line",     dut_out,  exp_active ? 0 : 1);
      check("out_line_inv", inv_out,  exp_active ? 1 : 0);
      check("busy",         dut_busy, exp_busy);
      check("busy_inv",     inv_busy, exp_busy);
      check("pending",      dut_pend, exp_pend);
      check("pending_inv",  inv_pend, exp_pend);
      check("dropped",      dut_drop, exp_drop);
      check("dropped_inv",  inv_drop, exp_drop);
   end

   // ---------------------------------------------------------------------------
   // Directed vectors: bit i of vec is sampled at relative posedge i; outputs
   // after posedge k are observed at the following negedge.
   // ---------------------------------------------------------------------------
   int starts_obs[$];
   int widths[$];
   int drop_idx;
   int pend_log [0:63];

   function automatic int q_get(input int q[$], input int idx);
      return (idx < q.size()) ? q[idx] : -1;
   endfunction

   task automatic run_vec(input logic [15:0] vec, input string name, input int e_pulses,
                          input int e_drops, input int e_busy, input int e_maxpend);
      int   pulses = 0;
      int   drops  = 0;
      int   busy_n = 0;
      int   maxp   = 0;
      int   k;
      logic act;
      logic prev_act = 1'b0;
      starts_obs.delete();
      widths.delete();
      drop_idx = -1;
      for (int i = 0; i <= 46; i++) begin
         @(negedge clk);
         in_edge = (i < 16) ? vec[i] : 1'b0;
         if (i > 0) begin
            k   = i - 1;
            act = (dut_out == 1'b0);
            if (act && !prev_act) begin
               pulses++;
               starts_obs.push_back(k);
               widths.push_back(0);
            end
            if (act) widths[widths.size() - 1]++;
            prev_act = act;
            if (dut_busy) busy_n++;
            if (dut_drop) begin
               drops++;
               drop_idx = k;
            end
            pend_log[k] = int'(dut_pend);
            if (int'(dut_pend) > maxp) maxp = int'(dut_pend);
         end
      end
      in_edge = 1'b0;
      check({name, "_pulses"},  pulses, e_pulses);
      check({name, "_drops"},   drops,  e_drops);
      check({name, "_busy"},    busy_n, e_busy);
      check({name, "_maxpend"}, maxp,   e_maxpend);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      // 1: idle after reset
      repeat (20) @(negedge clk);
      check("t1_out",     dut_out,  1);
      check("t1_out_inv", inv_out,  0);
      check("t1_busy",    dut_busy, 0);
      check("t1_pending", dut_pend, 0);
      check("t1_dropped", dut_drop, 0);

      // 2: single event -> 4 active cycles, 7 busy cycles
      run_vec(16'b0000_0000_0000_0001, "t2", 1, 0, 7, 0);
      check("t2_start", q_get(starts_obs, 0), 0);
      check("t2_width", q_get(widths, 0), 4);

      // 3: events at 0,2,3 -> pulses at 0,7,14, pending up to 2
      run_vec(16'b0000_0000_0000_1101, "t3", 3, 0, 21, 2);
      check("t3_start1", q_get(starts_obs, 1), 7);
      check("t3_start2", q_get(starts_obs, 2), 14);
      check("t3_width2", q_get(widths, 2), 4);
      check("t3_pend3",  pend_log[3], 2);
      check("t3_pend14", pend_log[14], 0);

      // 4: events at 0..3 -> queue saturates, event at 3 dropped
      run_vec(16'b0000_0000_0000_1111, "t4", 3, 1, 21, 2);
      check("t4_drop_idx", drop_idx, 3);

      // 5: event in the last gap cycle with one queued -> pending stays 1
      run_vec(16'b0000_0000_1000_0011, "t5", 3, 0, 21, 1);
      check("t5_pend7",  pend_log[7], 1);
      check("t5_start2", q_get(starts_obs, 2), 14);

      // 6: asynchronous reset mid-pulse with one event queued
      @(negedge clk); in_edge = 1'b1;
      @(negedge clk);
      @(negedge clk); in_edge = 1'b0;
      check("t6_active_pre",  dut_out,  0);
      check("t6_pending_pre", dut_pend, 1);
      #2 rst_n = 1'b0;
      #1;
      check("t6_rst_out",     dut_out,  1);
      check("t6_rst_out_inv", inv_out,  0);
      check("t6_rst_pending", dut_pend, 0);
      check("t6_rst_busy",    dut_busy, 0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      run_vec(16'b0000_0000_0000_0001, "t6", 1, 0, 7, 0);
      check("t6_width", q_get(widths, 0), 4);

      repeat (5) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #100000;
      n_fail++;
      $display("FAIL watchdog: simulation did not complete in time");
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_event_pulser
